// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - shared constants and types for the friscv fetch path
package friscv_pkg;

  localparam int unsigned INST_ALIGN = 4;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/friscv_fetch_fifo.sv
// rtl/friscv_fetch_fifo.sv - synchronous instruction buffer with flush
module friscv_fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/friscv_fetcher.sv
// rtl/friscv_fetcher.sv - credit-based instruction fetcher with flush/redirect
module friscv_fetcher
  import friscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter int              DEPTH     = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            fetch_en,
  input  logic            flush_req,
  input  logic [XLEN-1:0] flush_addr,
  output logic            arvalid,
  input  logic            arready,
  output logic [XLEN-1:0] araddr,
  input  logic            rvalid,
  output logic            rready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err
);

  localparam int              CW         = $clog2(DEPTH + 1);
  localparam int              FW         = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_ALIGN - 1);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ar_pend;
  logic            ar_hs;
  logic            credit_ok;
  logic            push;
  logic [FW-1:0]   head;

  // In-flight requests plus buffered entries never exceed the buffer size,
  // so every response always has a slot waiting for it.
  assign credit_ok = ~fifo_full &
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
  assign ar_hs     = arvalid & arready;
  assign push      = rvalid & ~flush_req & (discard == '0);
  assign araddr    = pc & ALIGN_MASK;
  assign rready    = 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      // A pending request stays up even if fetch_en drops before arready.
      RUN:  arvalid = ~flush_req & (ar_pend | (fetch_en & credit_ok));
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pc          <= BOOT_ADDR;
      rsp_pc      <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      ar_pend     <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(ar_hs) - CW'(rvalid);
      ar_pend     <= arvalid & ~arready;
      if (flush_req) begin
        pc      <= flush_addr & ALIGN_MASK;
        rsp_pc  <= flush_addr & ALIGN_MASK;
        discard <= outstanding - CW'(rvalid);
      end else begin
        if (ar_hs) pc <= pc + XLEN'(INST_ALIGN);
        // Responses return in order, so the next kept one belongs to rsp_pc.
        if (push) rsp_pc <= rsp_pc + XLEN'(INST_ALIGN);
        if (rvalid && discard != '0) discard <= discard - 1'b1;
      end
    end
  end

  friscv_fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data ({rresp != RESP_OKAY, rsp_pc, rdata}),
    .pop       (inst_ready & ~flush_req),
    .pop_data  (head),
    .flush     (flush_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid = ~fifo_empty;
  assign inst_err   = head[FW-1];
  assign inst_pc    = head[FW-2 -: XLEN];
  assign inst       = head[XLEN-1:0];

endmodule

// File: tb/tb_friscv_fetcher.sv
// tb/tb_friscv_fetcher.sv - randomized fetcher bench against an in-order memory/fetch model
module tb_friscv_fetcher;

  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_1000;

  logic            aclk;
  logic            aresetn;
  logic            fetch_en;
  logic            flush_req;
  logic [XLEN-1:0] flush_addr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_err;

  friscv_fetcher #(
    .XLEN      (XLEN),
    .BOOT_ADDR (BOOT_ADDR),
    .DEPTH     (DEPTH)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .fetch_en   (fetch_en),
    .flush_req  (flush_req),
    .flush_addr (flush_addr),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_err   (inst_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    bit          err;
  } ent_t;

  req_t        mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] pc_m;
  bit          boot;
  bit          held;
  int          cyc;
  int          hs_count;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn    = 1'b0;
    fetch_en   = 1'b0;
    arready    = 1'b0;
    inst_ready = 1'b0;
    flush_req  = 1'b0;
    flush_addr = '0;
    rvalid     = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    #1;
    check_eq("rst_arvalid",    64'(arvalid),    64'd0);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst",       64'(inst),       64'd0);
    check_eq("rst_inst_pc",    64'(inst_pc),    64'd0);
    check_eq("rst_inst_err",   64'(inst_err),   64'd0);
    check_eq("rst_araddr",     64'(araddr),     64'(BOOT_ADDR));
    mem_q.delete();
    exp_q.delete();
    pc_m = BOOT_ADDR;
    boot = 1'b1;
    held = 1'b0;
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
  endtask

  task automatic run_phase(input int ncyc, input int p_fe, input int p_ard, input int p_ird,
                           input int p_fl, input int p_rv, input int max_lat, input int p_err,
                           input bit gap_chk);
    bit   exp_av;
    bit   dut_hs;
    bit   pop_s;
    req_t r;
    ent_t e;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge aclk);
      fetch_en   = ($urandom_range(0, 99) < p_fe);
      arready    = ($urandom_range(0, 99) < p_ard);
      inst_ready = ($urandom_range(0, 99) < p_ird);
      flush_req  = ($urandom_range(0, 99) < p_fl);
      flush_addr = 32'h0000_2000 + ($urandom_range(0, 63) << 2);
      rvalid     = 1'b0;
      rdata      = '0;
      rresp      = 2'b00;
      if (mem_q.size() > 0 && cyc >= mem_q[0].due && $urandom_range(0, 99) < p_rv) begin
        rvalid = 1'b1;
        rdata  = $urandom;
        if (mem_q[0].pc == 32'h0000_1004)
          rresp = 2'b10;
        else if ($urandom_range(0, 99) < p_err)
          rresp = 2'($urandom_range(1, 3));
      end
      #1;
      exp_av = !boot && !flush_req &&
               (held || (fetch_en && (mem_q.size() + exp_q.size() < DEPTH)));
      check_eq("arvalid", 64'(arvalid), 64'(exp_av));
      if (arvalid) check_eq("araddr", 64'(araddr), 64'(pc_m));
      check_eq("rready", 64'(rready), 64'd1);
      check_eq("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
      if (inst_valid && exp_q.size() != 0) begin
        check_eq("inst",     64'(inst),     64'(exp_q[0].data));
        check_eq("inst_pc",  64'(inst_pc),  64'(exp_q[0].pc));
        check_eq("inst_err", 64'(inst_err), 64'(exp_q[0].err));
      end
      if (gap_chk && i >= 3) check_eq("no_gap", 64'(inst_valid), 64'd1);
      dut_hs = arvalid && arready;
      pop_s  = inst_valid && inst_ready;
      @(posedge aclk);
      if (dut_hs) hs_count++;
      if (flush_req) begin
        if (rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        foreach (mem_q[k]) mem_q[k].stale = 1'b1;
        exp_q.delete();
        pc_m = flush_addr & ~32'h3;
        held = 1'b0;
      end else begin
        if (pop_s && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rvalid && mem_q.size() > 0) begin
          r = mem_q.pop_front();
          if (!r.stale) begin
            e.data = rdata;
            e.pc   = r.pc;
            e.err  = (rresp != 2'b00);
            exp_q.push_back(e);
          end
        end
        if (dut_hs) begin
          r.pc    = pc_m;
          r.due   = cyc + 1 + $urandom_range(0, max_lat);
          r.stale = 1'b0;
          mem_q.push_back(r);
          pc_m = pc_m + 32'd4;
        end
        held = exp_av && !arready;
      end
      boot = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    hs_count = 0;
    aresetn  = 1'b0;

    do_reset();
    run_phase(30, 100, 100, 100, 0, 100, 0, 0, 1'b1);

    do_reset();
    hs_count = 0;
    run_phase(20, 100, 100, 0, 0, 100, 0, 0, 1'b0);
    check_eq("fill_limit", 64'(hs_count), 64'(DEPTH));

    for (int p = 0; p < 8; p++)
      run_phase(300, $urandom_range(50, 100), $urandom_range(30, 100), $urandom_range(20, 100),
                $urandom_range(0, 8), $urandom_range(40, 100), $urandom_range(0, 4), 10, 1'b0);

    run_phase(12, 100, 100, 0, 0, 60, 3, 10, 1'b0);
    do_reset();
    run_phase(300, 80, 70, 70, 4, 80, 3, 10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/friscv_fetcher.md
FRISCV_FETCHER -- requirements
Module: friscv_fetcher

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction and address width.
REQ-002 SHALL have parameter BOOT_ADDR, default 0, meaning the first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the instruction buffer depth (power of 2, at least 2).
REQ-004 SHALL have port aclk, input, 1 bit: the single clock.
REQ-005 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port fetch_en, input, 1 bit: enables issue of new read requests.
REQ-007 SHALL have port flush_req, input, 1 bit: redirect the fetch stream to flush_addr.
REQ-008 SHALL have port flush_addr, input, XLEN bits: the redirect target.
REQ-009 SHALL have ports arvalid (output, 1), arready (input, 1) and araddr (output, XLEN): the memory read request.
REQ-010 SHALL have ports rvalid (input, 1), rready (output, 1), rdata (input, XLEN) and rresp (input, 2): the memory read response.
REQ-011 SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst (output, XLEN), inst_pc (output, XLEN) and inst_err (output, 1): the instruction output to the decoder/control stage.

Function
REQ-012 SHALL keep a fetch PC. The PC advances by 4 on each request handshake (arvalid and arready).
REQ-013 SHALL drive araddr from the fetch PC. The low 2 bits are always 0.
REQ-014 SHALL assert arvalid only when all of these hold:
- fetch_en is 1;
- no flush_req is present;
- outstanding + occupancy < DEPTH.
REQ-015 SHALL hold araddr and arvalid stable while arvalid=1 and arready=0, except on flush.
REQ-016 SHALL hold rready at 1 at all times. The credit rule in REQ-014 guarantees there is buffer space.
REQ-017 SHALL write each non-discarded response into the FIFO with:
- rdata;
- its request address;
- err = (rresp != 0).
REQ-018 SHALL present the FIFO head on inst, inst_pc and inst_err with inst_valid = not empty. The entry pops on inst_valid and inst_ready.
REQ-019 SHALL give minimum latency as follows:
- request handshake in cycle N;
- response in cycle N+1 or later;
- inst_valid in the cycle after the response.
REQ-020 SHALL track an outstanding counter (0..DEPTH):
- +1 on a request handshake;
- -1 on a response;
- unchanged if both occur in the same cycle.
REQ-021 SHALL do the following on flush_req:
- empty the FIFO in the same cycle, so inst_valid=0 next cycle;
- load PC with flush_addr;
- load discard counter = outstanding - (1 if rvalid this cycle else 0);
- issue no request that cycle.
REQ-022 SHALL drop responses while the discard counter is nonzero, decrementing the counter on each. Responses that arrive in the flush cycle itself are dropped.
REQ-023 SHALL allow new requests to issue while discarding, but SHALL block them once outstanding = DEPTH.
REQ-024 SHALL ignore a pop from inst_ready in a flush cycle. A flush takes priority over push and pop.
REQ-025 SHALL let the FIFO accept a push and a pop in the same cycle when full or empty without loss. The empty case is a bypass-free write, so the entry becomes visible next cycle.
REQ-026 SHALL let fetch_en=0 stop new requests only. Outstanding responses still complete and fill the FIFO.
REQ-027 SHALL give a state machine with two states:
- BOOT: one cycle after reset, PC = BOOT_ADDR, no request;
- RUN: normal operation.

Reset
REQ-028 SHALL, on aresetn=0, asynchronously set:
- PC = BOOT_ADDR;
- outstanding = 0;
- discard = 0;
- FIFO empty;
- state = BOOT;
- arvalid = 0, inst_valid = 0.
REQ-029 SHALL, while in reset, hold the data outputs inst, inst_pc and inst_err at 0, and araddr at BOOT_ADDR.
REQ-030 SHALL abandon a read in flight when reset is asserted mid-transfer. The memory side is reset from the same aresetn.

Structure
REQ-031 SHALL place these in friscv_pkg: the constant for instruction alignment (4 bytes) and the OKAY response code (2'b00).
REQ-032 SHALL implement the buffer as sub-module friscv_fetch_fifo. It is a synchronous FIFO with width 2*XLEN+1, parameter DEPTH, ports push/pop/flush, and full, empty and count outputs.
REQ-033 SHALL keep all remaining logic in friscv_fetcher: PC, credit, discard and the state machine.

Verification
REQ-034 Reset release with BOOT_ADDR=0x1000, fetch_en=1, arready=1, memory latency 1 -> araddr sequence 0x1000, 0x1004, 0x1008…; inst_pc matches the sequence; no gaps once inst_ready=1.
REQ-035 inst_ready=0, DEPTH=4, arready=1 -> exactly 4 requests accepted; arvalid stays 0 until the first pop.
REQ-036 Flush to 0x2000 with 3 requests outstanding -> those 3 responses dropped; first inst_pc = 0x2000; inst_valid=0 in the cycle after the flush.
REQ-037 Flush in the same cycle as rvalid and inst_ready -> the response is dropped, no pop is counted, and the discard counter is 1 lower than outstanding.
REQ-038 rresp=2'b10 on the response for 0x1004 -> inst_err=1 only with inst_pc=0x1004.
REQ-039 aresetn asserted with 2 outstanding and FIFO holding 2 entries -> next cycle inst_valid=0 and arvalid=0; after release the fetch restarts at BOOT_ADDR.
